// File: rtl/io_map_pkg.sv
// Shared IO map definitions: UART register offsets, STATUS bit positions
// and the transmitter FSM state encoding.
package io_map_pkg;

   // Word offsets from the UART base address
   localparam logic [13:0] UART_TXDATA = 14'd0;
   localparam logic [13:0] UART_STATUS = 14'd1;
   localparam logic [13:0] UART_DIV    = 14'd2;
   localparam logic [13:0] UART_CTRL   = 14'd3;

   // STATUS bit positions; [7:0] carries the FIFO level
   localparam int unsigned ST_EMPTY = 8;
   localparam int unsigned ST_FULL  = 9;
   localparam int unsigned ST_BUSY  = 10;
   localparam int unsigned ST_OVF   = 11;

   // Smallest divisor the bit timer supports
   localparam logic [15:0] DIV_MIN = 16'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/io_uart_tx_fifo.sv
// Transmit byte FIFO: 2^FIFO_LOG2 entries, pointers one bit wider than the
// address so full and empty are distinguishable. A push while full is
// accepted only when a pop happens in the same cycle.
module io_uart_tx_fifo
   import io_map_pkg::*;
#(
   parameter int unsigned FIFO_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic [7:0] level,
   output logic       full,
   output logic       empty
);

   localparam int unsigned DEPTH = 1 << FIFO_LOG2;

   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_LOG2:0] wptr_q, wptr_d;
   logic [FIFO_LOG2:0] rptr_q, rptr_d;
   logic [FIFO_LOG2:0] count;
   logic               do_push, do_pop;

   // Flag decode and pointer advance; full is judged after a same-cycle pop
   always_comb begin
      count   = wptr_q - rptr_q;
      empty   = (wptr_q == rptr_q);
      full    = (wptr_q[FIFO_LOG2] != rptr_q[FIFO_LOG2]) &&
                (wptr_q[FIFO_LOG2-1:0] == rptr_q[FIFO_LOG2-1:0]);
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      wptr_d  = wptr_q + {{FIFO_LOG2{1'b0}}, do_push};
      rptr_d  = rptr_q + {{FIFO_LOG2{1'b0}}, do_pop};
      level   = '0;
      level[FIFO_LOG2:0] = count;
      rdata   = mem_q[rptr_q[FIFO_LOG2-1:0]];
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage array, written on accepted pushes only
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[FIFO_LOG2-1:0]] <= wdata;
   end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the dma_io register bus.
// Optional feature macro: UART_TX_IRQ_EN enables CTRL.ien and uart_irq;
// without it CTRL reads 0, ignores writes and uart_irq is tied low.
module io_uart_tx
   import io_map_pkg::*;
#(
   parameter logic [13:0] BASE_ADR  = 14'h3C00,
   parameter int unsigned FIFO_LOG2 = 4,
   parameter logic [15:0] DIV_RST   = 16'd434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dma_io_we,
   input  logic [15:2] dma_io_wadr,
   input  logic [31:0] dma_io_wdata,
   input  logic [15:2] dma_io_radr,
   input  logic        dma_io_radr_en,
   output logic [31:0] io_rdata,
   output logic        uart_tx,
   output logic        uart_irq
);

   uart_state_e state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [15:0] bit_div_q, bit_div_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        tx_q, tx_d;
   logic        ovf_q, ovf_d;
   logic [31:0] rdata_q, rdata_d;
   logic        bit_end;

   logic        wr_tx, wr_status, wr_div;
   logic        fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_rdata, fifo_level;
   logic        ien_rd;
   logic [31:0] status;
   logic        unused_wdata;

   assign wr_tx        = dma_io_we && (dma_io_wadr == BASE_ADR + UART_TXDATA);
   assign wr_status    = dma_io_we && (dma_io_wadr == BASE_ADR + UART_STATUS);
   assign wr_div       = dma_io_we && (dma_io_wadr == BASE_ADR + UART_DIV);
   assign unused_wdata = ^dma_io_wdata[31:16];

   io_uart_tx_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_tx),
      .wdata (dma_io_wdata[7:0]),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef UART_TX_IRQ_EN
   logic wr_ctrl;
   logic ien_q, ien_d;
   logic irq_q, irq_d;

   assign wr_ctrl = dma_io_we && (dma_io_wadr == BASE_ADR + UART_CTRL);

   // Interrupt enable register and level interrupt (idle with nothing queued)
   always_comb begin
      ien_d = ien_q;
      if (wr_ctrl) ien_d = dma_io_wdata[0];
      irq_d = ien_q & fifo_empty & (state_q == IDLE);
   end

   // Interrupt state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ien_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         ien_q <= ien_d;
         irq_q <= irq_d;
      end
   end

   assign ien_rd   = ien_q;
   assign uart_irq = irq_q;
`else
   assign ien_rd   = 1'b0;
   assign uart_irq = 1'b0;
`endif

   // Divisor and sticky overflow register updates
   always_comb begin
      div_d = div_q;
      if (wr_div) div_d = (dma_io_wdata[15:0] < DIV_MIN) ? DIV_MIN : dma_io_wdata[15:0];
      ovf_d = ovf_q;
      if (wr_status) ovf_d = 1'b0;
      if (wr_tx && fifo_full && !fifo_pop) ovf_d = 1'b1;
   end

   // Frame sequencer: next state, bit timer, shift register and line level
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      bit_div_d = bit_div_q;
      fifo_pop  = 1'b0;
      bit_end   = (cnt_q == '0);
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shreg_d   = fifo_rdata;
               bit_div_d = div_q;
               cnt_d     = div_q - 16'd1;
               state_d   = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = '0;
               cnt_d   = bit_div_q - 16'd1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d   = bit_div_q - 16'd1;
               shreg_d = {1'b0, shreg_q[7:1]};
               if (idx_q == 3'd7) state_d = STOP;
               else idx_d = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         STOP: begin
            if (bit_end) state_d = IDLE;
            else cnt_d = cnt_q - 16'd1;
         end
         default: state_d = IDLE;
      endcase
      // Line level is registered from the next state so it lines up with it
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // Registered read mux; unselected or undecoded addresses return 0
   always_comb begin
      status                 = '0;
      status[7:0]            = fifo_level;
      status[ST_EMPTY]       = fifo_empty;
      status[ST_FULL]        = fifo_full;
      status[ST_BUSY]        = (state_q != IDLE);
      status[ST_OVF]         = ovf_q;
      rdata_d                = '0;
      if (dma_io_radr_en) begin
         if (dma_io_radr == BASE_ADR + UART_STATUS)    rdata_d = status;
         else if (dma_io_radr == BASE_ADR + UART_DIV)  rdata_d = {16'd0, div_q};
         else if (dma_io_radr == BASE_ADR + UART_CTRL) rdata_d = {31'd0, ien_rd};
      end
   end

   // State registers; the line idles high out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         div_q     <= DIV_RST;
         bit_div_q <= DIV_MIN;
         cnt_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         tx_q      <= 1'b1;
         ovf_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_div_q <= bit_div_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         tx_q      <= tx_d;
         ovf_q     <= ovf_d;
         rdata_q   <= rdata_d;
      end
   end

   assign io_rdata = rdata_q;
   assign uart_tx  = tx_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: a timeline/queue model of the transmitter checked
// against the DUT outputs every cycle, plus directed literal expectations.
module tb_io_uart_tx;

   localparam logic [13:0] BASE  = 14'h3C00;
   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we, ren;
   logic [13:0] wadr, radr;
   logic [31:0] wdata;
   logic [31:0] io_rdata;
   logic        uart_tx, uart_irq;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   io_uart_tx #(.BASE_ADR(14'h3C00), .FIFO_LOG2(4), .DIV_RST(16'd434)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .dma_io_we      (we),
      .dma_io_wadr    (wadr),
      .dma_io_wdata   (wdata),
      .dma_io_radr    (radr),
      .dma_io_radr_en (ren),
      .io_rdata       (io_rdata),
      .uart_tx        (uart_tx),
      .uart_irq       (uart_irq)
   );

   // ---------------- behavioural model ----------------
   // A frame popped in cycle p occupies cycles p+1 .. p+10*d; bit k of the
   // frame {stop, data[7:0], start} is on the line for cycles p+1+k*d ..
   logic [7:0]  mq[$];
   int unsigned m_cyc, m_p, m_d;
   bit          m_act, m_ovf, m_ien;
   logic [7:0]  m_byte;
   logic [15:0] m_div;
   logic        m_tx, m_irq;
   logic [31:0] m_rd;

   function automatic bit m_busy(input int unsigned c);
      return m_act && (c >= m_p + 1) && (c <= m_p + 10 * m_d);
   endfunction

   function automatic logic m_line(input int unsigned c);
      logic [9:0]  fr;
      int unsigned k;
      if (!m_busy(c)) return 1'b1;
      fr = {1'b1, m_byte, 1'b0};
      k  = (c - m_p - 1) / m_d;
      return fr[k];
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int unsigned lvl;
      bit          bz, pop, fullc;
      logic [13:0] woff, roff;
      logic [31:0] rd;
      if (!rst_n) begin
         mq.delete();
         m_cyc = 0; m_p = 0; m_d = 2; m_act = 0; m_byte = '0;
         m_ovf = 0; m_ien = 0; m_div = 16'd434;
         m_tx = 1'b1; m_irq = 1'b0; m_rd = '0;
      end else begin
         lvl   = mq.size();
         bz    = m_busy(m_cyc);
         fullc = (lvl == DEPTH);
         pop   = !bz && lvl != 0;
         roff  = radr - BASE;
         woff  = wadr - BASE;
         rd    = '0;
         if (ren) begin
            case (roff)
               14'd1:   rd = {20'd0, m_ovf, bz, fullc, lvl == 0, lvl[7:0]};
               14'd2:   rd = {16'd0, m_div};
`ifdef UART_TX_IRQ_EN
               14'd3:   rd = {31'd0, m_ien};
`endif
               default: rd = '0;
            endcase
         end
`ifdef UART_TX_IRQ_EN
         m_irq = m_ien && lvl == 0 && !bz;
`else
         m_irq = 1'b0;
`endif
         if (pop) begin
            m_p = m_cyc; m_d = m_div; m_byte = mq.pop_front(); m_act = 1;
         end
         if (we) begin
            case (woff)
               14'd0: if (!fullc || pop) mq.push_back(wdata[7:0]); else m_ovf = 1;
               14'd1: m_ovf = 0;
               14'd2: m_div = (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
`ifdef UART_TX_IRQ_EN
               14'd3: m_ien = wdata[0];
`endif
               default: ;
            endcase
         end
         m_cyc = m_cyc + 1;
         m_tx  = m_line(m_cyc);
         m_rd  = rd;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("tx_model", {31'd0, uart_tx}, {31'd0, m_tx});
         chk("irq_model", {31'd0, uart_irq}, {31'd0, m_irq});
         chk("rdata_model", io_rdata, m_rd);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_in(input bit w, input logic [13:0] wa, input logic [31:0] wd,
                         input bit r, input logic [13:0] ra);
      we = w; wadr = wa; wdata = wd; ren = r; radr = ra;
   endtask

   task automatic io(input bit w, input logic [13:0] wa, input logic [31:0] wd,
                     input bit r, input logic [13:0] ra);
      @(negedge clk);
      set_in(w, wa, wd, r, ra);
   endtask

   task automatic idle();
      io(0, '0, '0, 0, '0);
   endtask

   task automatic wr(input logic [13:0] off, input logic [31:0] d);
      io(1, BASE + off, d, 0, '0);
   endtask

   task automatic rd_chk(input string nm, input logic [13:0] off, input logic [31:0] exp);
      io(0, '0, '0, 1, BASE + off);
      idle();
      chk(nm, io_rdata, exp);
   endtask

   task automatic drain(input int unsigned limit);
      bit done;
      done = 0;
      for (int i = 0; i < limit; i++) begin
         if (mq.size() == 0 && !m_busy(m_cyc)) begin
            done = 1;
            break;
         end
         idle();
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: level %0d still queued after %0d cycles", mq.size(), limit);
      end
      idle();
      idle();
   endtask

   // ---------------- test sequence ----------------
   initial begin : main
      logic [9:0] fr;
      logic       exp_tx;
      int unsigned k;
      bit hit;

      rst_n = 1'b0;
      set_in(0, '0, '0, 0, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle();

      // Reset state
      chk("rst_tx", {31'd0, uart_tx}, 32'd1);
      chk("rst_irq", {31'd0, uart_irq}, 32'd0);
      chk("rst_rdata", io_rdata, 32'd0);
      rd_chk("rst_status", 14'd1, 32'h100);
      rd_chk("rst_div", 14'd2, 32'd434);
      rd_chk("rst_ctrl", 14'd3, 32'd0);
      rd_chk("txdata_reads0", 14'd0, 32'd0);

      // DIVISOR=4, single 0x55 frame pinned cycle by cycle
      wr(14'd2, 32'd4);
      idle();
      wr(14'd0, 32'h55);
      fr = {1'b1, 8'h55, 1'b0};
      for (int j = 1; j <= 41; j++) begin
         idle();
         if (j < 2) exp_tx = 1'b1;
         else begin
            k = (j - 2) / 4;
            exp_tx = fr[k];
         end
         chk("frame55", {31'd0, uart_tx}, {31'd0, exp_tx});
      end
      io(0, '0, '0, 1, BASE + 14'd1);
      chk("frame55_end", {31'd0, uart_tx}, 32'd1);
      idle();
      chk("busy_clear", io_rdata, 32'h100);

      // DIVISOR=2, overfill the FIFO while the line is busy
      wr(14'd2, 32'd2);
      idle();
      wr(14'd0, 32'hA0);
      repeat (3) idle();
      for (int i = 0; i < 17; i++) wr(14'd0, 32'h10 + i);
      rd_chk("status_full_ovf", 14'd1, 32'hE10);
      wr(14'd1, 32'd0);
      rd_chk("status_ovf_cleared", 14'd1, 32'h40F);

      // Refill to full, then push in the very cycle the FSM pops
      wr(14'd0, 32'h21);
      hit = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!m_busy(m_cyc) && mq.size() == DEPTH) begin
            set_in(1, BASE, 32'h3C, 0, '0);
            hit = 1;
            break;
         end
         set_in(0, '0, '0, 0, '0);
      end
      if (!hit) begin
         total++;
         bad++;
         $display("FAIL pop_window_timeout: no pop with full FIFO within 200 cycles");
      end
      rd_chk("push_on_pop", 14'd1, 32'h610);
      drain(1000);

      // Interrupt behaviour
`ifdef UART_TX_IRQ_EN
      wr(14'd3, 32'd1);
      idle(); idle();
      chk("irq_idle", {31'd0, uart_irq}, 32'd1);
      rd_chk("ctrl_rb", 14'd3, 32'd1);
      wr(14'd0, 32'h81);
      idle(); idle();
      chk("irq_push_drop", {31'd0, uart_irq}, 32'd0);
      drain(200);
      chk("irq_after_stop", {31'd0, uart_irq}, 32'd1);
      wr(14'd3, 32'd0);
      idle(); idle();
      chk("irq_ien_clear", {31'd0, uart_irq}, 32'd0);
`else
      wr(14'd3, 32'd1);
      idle(); idle();
      chk("irq_tied", {31'd0, uart_irq}, 32'd0);
      rd_chk("ctrl_reads0", 14'd3, 32'd0);
`endif

      // Register read-back and decode boundaries
      rd_chk("div_rb", 14'd2, 32'd2);
      rd_chk("offset8", 14'd8, 32'd0);
      wr(14'd2, 32'd0);
      rd_chk("div_min", 14'd2, 32'd2);
      io(1, BASE + 14'd2, 32'd7, 1, BASE + 14'd2);
      idle();
      chk("rd_old_on_wr", io_rdata, 32'd2);
      chk("rd_one_cycle", io_rdata, 32'd2);
      idle();
      chk("rd_then_zero", io_rdata, 32'd0);
      rd_chk("div_new", 14'd2, 32'd7);

      // Randomized traffic
      wr(14'd2, 32'd2);
      for (int i = 0; i < 3000; i++) begin
         int unsigned r;
         bit          rw, rr;
         logic [13:0] wa, ra;
         logic [31:0] wd;
         r  = $urandom_range(0, 99);
         rw = 1;
         wd = $urandom;
         if (r < 12)      wa = BASE;
         else if (r < 14) begin wa = BASE + 14'd2; wd = $urandom_range(0, 4); end
         else if (r < 16) wa = BASE + 14'd1;
         else if (r < 18) wa = BASE + 14'd3;
         else if (r < 20) wa = (r[0]) ? BASE - 14'd1 : BASE + 14'(4 + $urandom_range(0, 3));
         else begin rw = 0; wa = '0; end
         rr = ($urandom_range(0, 1) == 1);
         ra = ($urandom_range(0, 7) == 7) ? BASE - 14'd1 : BASE + 14'($urandom_range(0, 5));
         io(rw, wa, wd, rr, ra);
      end
      drain(2000);

      // Asynchronous reset in the middle of a data bit that is low
      wr(14'd2, 32'd8);
      idle();
      wr(14'd0, 32'h3C);
      repeat (14) idle();
      chk("pre_reset_low", {31'd0, uart_tx}, 32'd0);
      #1 rst_n = 1'b0;
      #1 chk("async_tx_high", {31'd0, uart_tx}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rd_chk("post_rst_status", 14'd1, 32'h100);
      rd_chk("post_rst_div", 14'd2, 32'd434);
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
